// File: rtl/mux_sync_rx.sv
// Captures a foreign-domain bus into a valid/ready holding register. Each synchronised enable event loads it once.
// A load lands SYNC_STAGES+1 edges after en_async changes. While the buffer is full, a new word is either dropped or overwrites the held one.
module mux_sync_rx #(
   parameter int DW          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 0,
   parameter int OVERWRITE   = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_async,
   input  logic [DW-1:0]    data_async,
   input  logic             out_ready,
   input  logic             ovf_clr,
   output logic             out_valid,
   output logic [DW-1:0]    data_out,
   output logic             overflow,
   output logic [CNT_W-1:0] cap_cnt
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   en_d_q;
   logic                   en_s;
   logic                   evt;
   logic                   load;
   logic                   ovf_set;
   logic [DW-1:0]          data_q, data_d;
   logic                   ovf_q, ovf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   assign en_s = sync_q[SYNC_STAGES-1];
   // Level mode fires on the rising edge only; toggle mode fires on either edge.
   assign evt  = (MODE == 1) ? (en_s ^ en_d_q) : (en_s & ~en_d_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         en_d_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], en_async};
         en_d_q <= en_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (evt) state_d = FULL;
         FULL:  if (out_ready && !evt) state_d = EMPTY;
      endcase
   end

   // An event with the consumer accepting the word on the same edge is a clean handover, not an overflow.
   always_comb begin
      out_valid = (state_q == FULL);
      load      = evt && ((state_q == EMPTY) || out_ready || (OVERWRITE != 0));
      ovf_set   = evt && (state_q == FULL) && !out_ready;
   end

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (load) begin
         data_d = data_async;
         cnt_d  = cnt_q + CNT_W'(1);
      end
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign data_out = data_q;
   assign overflow = ovf_q;
   assign cap_cnt  = cnt_q;
endmodule

// File: tb/tb_mux_sync_rx.sv
// Directed bench: u0 covers level mode with drop-on-overflow; u1 covers toggle mode with overwrite and a 4-bit counter.
module tb_mux_sync_rx;
   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1, en0 = 1'b0, rdy0 = 1'b0, clr0 = 1'b0;
   logic [7:0] dat0 = 8'h00;
   logic       vld0, ovf0;
   logic [7:0] dout0;
   logic [15:0] cnt0;

   logic       rst1 = 1'b1, en1 = 1'b0, rdy1 = 1'b0, clr1 = 1'b0;
   logic [7:0] dat1 = 8'h00;
   logic       vld1, ovf1;
   logic [7:0] dout1;
   logic [3:0] cnt1;

   mux_sync_rx #(.DW(8), .SYNC_STAGES(2), .MODE(0), .OVERWRITE(0), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst0), .en_async(en0), .data_async(dat0), .out_ready(rdy0),
      .ovf_clr(clr0), .out_valid(vld0), .data_out(dout0), .overflow(ovf0), .cap_cnt(cnt0));

   mux_sync_rx #(.DW(8), .SYNC_STAGES(2), .MODE(1), .OVERWRITE(1), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst1), .en_async(en1), .data_async(dat1), .out_ready(rdy1),
      .ovf_clr(clr1), .out_valid(vld1), .data_out(dout1), .overflow(ovf1), .cap_cnt(cnt1));

   typedef struct {
      logic        rst;
      logic        en;
      logic [7:0]  dat;
      logic        rdy;
      logic        clr;
      logic        vld;
      logic [7:0]  dout;
      logic        ovf;
      logic [15:0] cnt;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] seen[$];
   int         n_chk  = 0;
   int         n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Records every word presented by u1 so single-cycle loads can be checked in order.
   task automatic step1_rec();
      step();
      if (vld1) seen.push_back(dout1);
   endtask

   function automatic void add(input logic r, input logic e, input logic [7:0] d, input logic rd,
                               input logic c, input logic v, input logic [7:0] o, input logic f,
                               input logic [15:0] n);
      vec_t x;
      x.rst = r; x.en = e; x.dat = d; x.rdy = rd; x.clr = c;
      x.vld = v; x.dout = o; x.ovf = f; x.cnt = n;
      tbl.push_back(x);
   endfunction

   logic [7:0] tog_dat[4];

   initial begin
      // rst en dat rdy clr | vld dout ovf cnt
      add(0,1,8'hA5,1,0, 0,8'hA5,0,1);   // accept, data held
      add(0,0,8'h5A,1,0, 0,8'hA5,0,1);   // ready while empty ignored
      add(0,1,8'h5A,0,0, 0,8'hA5,0,1);
      add(0,1,8'h5A,0,0, 0,8'hA5,0,1);
      add(0,1,8'h5A,0,0, 1,8'h5A,0,2);   // load 5A
      add(0,0,8'hC3,0,0, 1,8'h5A,0,2);
      add(0,1,8'hC3,0,0, 1,8'h5A,0,2);
      add(0,1,8'hC3,0,0, 1,8'h5A,0,2);
      add(0,1,8'hC3,0,0, 1,8'h5A,1,2);   // overflow, C3 dropped
      add(0,1,8'hC3,0,1, 1,8'h5A,0,2);   // clear
      add(0,0,8'h77,0,0, 1,8'h5A,0,2);
      add(0,1,8'h77,0,0, 1,8'h5A,0,2);
      add(0,1,8'h77,0,0, 1,8'h5A,0,2);
      add(0,1,8'h77,1,0, 1,8'h77,0,3);   // accept + load same edge
      add(0,0,8'h88,0,0, 1,8'h77,0,3);
      add(0,1,8'h88,0,0, 1,8'h77,0,3);
      add(0,1,8'h88,0,0, 1,8'h77,0,3);
      add(0,1,8'h88,0,1, 1,8'h77,1,3);   // set wins over clear
      add(0,1,8'h88,0,0, 1,8'h77,1,3);
      add(0,0,8'h99,0,0, 1,8'h77,1,3);
      add(0,1,8'h99,0,0, 1,8'h77,1,3);
      add(1,0,8'h99,0,0, 0,8'h00,0,0);   // reset flushes pending event
      add(0,0,8'h99,0,0, 0,8'h00,0,0);
      add(0,0,8'h99,0,0, 0,8'h00,0,0);
      add(0,0,8'h99,0,0, 0,8'h00,0,0);

      // ---- u0: reset and first-load latency ----
      step(); step();
      chk("u0 reset vld", 32'(vld0), 0);
      chk("u0 reset dout", 32'(dout0), 0);
      chk("u0 reset ovf", 32'(ovf0), 0);
      chk("u0 reset cnt", 32'(cnt0), 0);
      rst0 = 1'b0; dat0 = 8'hA5; en0 = 1'b1;
      step();
      chk("u0 lat edge1 vld", 32'(vld0), 0);
      step();
      chk("u0 lat edge2 vld", 32'(vld0), 0);
      step();
      chk("u0 lat edge3 vld", 32'(vld0), 1);
      chk("u0 lat edge3 dout", 32'(dout0), 32'hA5);
      chk("u0 lat edge3 cnt", 32'(cnt0), 1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("u0 level hold %0d cnt", i), 32'(cnt0), 1);
      end
      chk("u0 level hold vld", 32'(vld0), 1);

      // ---- u0: table ----
      for (int i = 0; i < tbl.size(); i++) begin
         rst0 = tbl[i].rst; en0 = tbl[i].en; dat0 = tbl[i].dat;
         rdy0 = tbl[i].rdy; clr0 = tbl[i].clr;
         step();
         chk($sformatf("u0 vec%0d vld", i), 32'(vld0), 32'(tbl[i].vld));
         chk($sformatf("u0 vec%0d dout", i), 32'(dout0), 32'(tbl[i].dout));
         chk($sformatf("u0 vec%0d ovf", i), 32'(ovf0), 32'(tbl[i].ovf));
         chk($sformatf("u0 vec%0d cnt", i), 32'(cnt0), 32'(tbl[i].cnt));
      end

      // ---- u1: toggle mode, four spaced toggles, consumer always ready ----
      rst1 = 1'b0; rdy1 = 1'b1;
      tog_dat[0] = 8'h11; tog_dat[1] = 8'h22; tog_dat[2] = 8'h33; tog_dat[3] = 8'h44;
      for (int k = 0; k < 4; k++) begin
         dat1 = tog_dat[k];
         step1_rec();
         en1 = ~en1;
         for (int j = 0; j < 6; j++) step1_rec();
      end
      chk("u1 toggle loads", 32'(seen.size()), 4);
      for (int k = 0; k < 4 && k < seen.size(); k++)
         chk($sformatf("u1 toggle word%0d", k), 32'(seen[k]), 32'(tog_dat[k]));
      chk("u1 toggle cnt", 32'(cnt1), 4);
      chk("u1 toggle ovf", 32'(ovf1), 0);

      // ---- u1: overwrite on overflow ----
      rdy1 = 1'b0; dat1 = 8'h5A;
      step(); en1 = ~en1;
      for (int j = 0; j < 4; j++) step();
      chk("u1 ow first dout", 32'(dout1), 32'h5A);
      dat1 = 8'hC3;
      step(); en1 = ~en1;
      for (int j = 0; j < 4; j++) step();
      chk("u1 ow dout", 32'(dout1), 32'hC3);
      chk("u1 ow ovf", 32'(ovf1), 1);
      chk("u1 ow cnt", 32'(cnt1), 6);
      chk("u1 ow vld", 32'(vld1), 1);

      // ---- u1: reset with enable high, then back-to-back toggles through wrap ----
      rst1 = 1'b1; en1 = 1'b1;
      step(); step();
      chk("u1 rst vld", 32'(vld1), 0);
      chk("u1 rst cnt", 32'(cnt1), 0);
      chk("u1 rst ovf", 32'(ovf1), 0);
      rst1 = 1'b0;
      for (int j = 0; j < 4; j++) step();
      chk("u1 rise after rst cnt", 32'(cnt1), 1);
      chk("u1 rise after rst vld", 32'(vld1), 1);
      rdy1 = 1'b1;
      for (int j = 0; j < 16; j++) begin
         en1 = ~en1;
         step();
      end
      for (int j = 0; j < 4; j++) step();
      chk("u1 wrap cnt", 32'(cnt1), 1);
      chk("u1 wrap ovf", 32'(ovf1), 0);
      chk("u1 wrap vld", 32'(vld1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
